// File: rtl/exc_irq_controller.sv
// Interrupt/exception entry and return sequencer for the 5-stage pipeline.
// Optional feature: define IRQ_LATCH_EN to latch IRQ rising edges into per-line pending bits.
module exc_irq_controller #(
  parameter int NUM_IRQ = 4,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_exc_undef,
  input  logic               i_eret,
  input  logic               i_id_valid,
  input  logic [31:0]        i_id_pc,
  input  logic               i_stall,
  input  logic               i_redirect,
  output logic               o_interrupt,
  output logic               o_exception,
  output logic [31:0]        o_epc,
  output logic [3:0]         o_cause,
  output logic [NUM_IRQ-1:0] o_irq_ack,
  output logic               o_in_handler
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HANDLER = 2'd1,
    S_RETURN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_epc;
  logic [3:0]         r_cause;
  logic [NUM_IRQ-1:0] r_irq_ack;

  logic [NUM_IRQ-1:0] w_req;
  logic [NUM_IRQ-1:0] w_onehot;
  logic [3:0]         w_idx;
  logic               w_take_ok;
  logic               w_interrupt;
  logic               w_exception;
  logic [NUM_IRQ-1:0] w_ack_mask;

`ifdef IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_pending;

  // A fresh rising edge on the cycle its line is acknowledged keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_d   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_d   <= i_irq;
      r_pending <= (r_pending & ~w_ack_mask) | (i_irq & ~r_irq_d);
    end
  end

  assign w_req = r_pending;
`else
  assign w_req = i_irq;
`endif

  // Lowest set index wins: scan high to low so the last hit is the winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_idx    = 4'd0;
    w_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_idx       = 4'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_take_ok   = ~reset & (r_state == S_IDLE) & i_id_valid & ~i_stall & ~i_id_pc[31];
  assign w_exception = w_take_ok & i_exc_undef;
  // Redirect defers only interrupts: the ID PC may belong to a squashed path.
  assign w_interrupt = w_take_ok & ~i_exc_undef & ~i_redirect & (|w_req);
  assign w_ack_mask  = {NUM_IRQ{w_interrupt}} & w_onehot;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_exception || w_interrupt) w_state_nxt = S_HANDLER;
      end
      S_HANDLER: begin
        if (i_eret && i_id_valid && !i_stall) begin
          w_state_nxt = S_RETURN;
          w_cnt_nxt   = CNT_W'(HOLDOFF - 1);
        end
      end
      S_RETURN: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_epc     <= '0;
      r_cause   <= '0;
      r_irq_ack <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_irq_ack <= w_ack_mask;
      if (w_exception) begin
        r_epc   <= i_id_pc + 32'd4;
        r_cause <= 4'hF;
      end else if (w_interrupt) begin
        // The ID instruction is flushed and re-executed after return.
        r_epc   <= i_id_pc;
        r_cause <= w_idx;
      end
    end
  end

  assign o_interrupt  = w_interrupt;
  assign o_exception  = w_exception;
  assign o_epc        = r_epc;
  assign o_cause      = r_cause;
  assign o_irq_ack    = r_irq_ack;
  assign o_in_handler = (r_state != S_IDLE);

endmodule

// File: tb/tb_exc_irq_controller.sv
// Directed testbench for exc_irq_controller (NUM_IRQ=4, HOLDOFF=2).
module tb_exc_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_irq;
  logic        i_exc_undef;
  logic        i_eret;
  logic        i_id_valid;
  logic [31:0] i_id_pc;
  logic        i_stall;
  logic        i_redirect;
  logic        o_interrupt;
  logic        o_exception;
  logic [31:0] o_epc;
  logic [3:0]  o_cause;
  logic [3:0]  o_irq_ack;
  logic        o_in_handler;

  int n_pass  = 0;
  int n_total = 0;

  exc_irq_controller #(.NUM_IRQ(4), .HOLDOFF(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_irq        (i_irq),
    .i_exc_undef  (i_exc_undef),
    .i_eret       (i_eret),
    .i_id_valid   (i_id_valid),
    .i_id_pc      (i_id_pc),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .o_interrupt  (o_interrupt),
    .o_exception  (o_exception),
    .o_epc        (o_epc),
    .o_cause      (o_cause),
    .o_irq_ack    (o_irq_ack),
    .o_in_handler (o_in_handler)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves HANDLER via eret; irq_during is driven while in RETURN, where no take may occur.
  task automatic do_return(input logic [3:0] irq_during);
    i_eret = 1'b1; i_id_valid = 1'b1; i_stall = 1'b0;
    tick();
    i_eret = 1'b0; i_irq = irq_during;
    #1;
    n_total++; if (o_in_handler !== 1'b1) $display("FAIL ret_in_handler1: got %b want 1", o_in_handler); else n_pass++;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL ret_no_take1: got %b want 0", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL ret_no_take2: got %b want 0", o_interrupt); else n_pass++;
    n_total++; if (o_in_handler !== 1'b1) $display("FAIL ret_in_handler2: got %b want 1", o_in_handler); else n_pass++;
    tick();
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL ret_idle: got %b want 0", o_in_handler); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_irq = 4'b0001; i_exc_undef = 1'b0; i_eret = 1'b0;
    i_id_valid = 1'b1; i_id_pc = 32'h0; i_stall = 1'b0; i_redirect = 1'b0;
    tick();
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL reset_int_low: got %b want 0", o_interrupt); else n_pass++;
    n_total++; if (o_epc !== 32'h0) $display("FAIL reset_epc: got %h want 0", o_epc); else n_pass++;
    n_total++; if (o_cause !== 4'h0) $display("FAIL reset_cause: got %h want 0", o_cause); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b0) $display("FAIL reset_ack: got %b want 0000", o_irq_ack); else n_pass++;
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL reset_in_handler: got %b want 0", o_in_handler); else n_pass++;
    reset = 1'b0; i_irq = 4'b0;
    tick();
  endtask

  task automatic test_irq_basic();
    i_irq = 4'b0110; i_id_pc = 32'h100; i_id_valid = 1'b1;
    #1;
    n_total++; if (o_interrupt !== 1'b1) $display("FAIL irq_take: got %b want 1", o_interrupt); else n_pass++;
    n_total++; if (o_exception !== 1'b0) $display("FAIL irq_no_exc: got %b want 0", o_exception); else n_pass++;
    tick();
    n_total++; if (o_epc !== 32'h100) $display("FAIL irq_epc: got %h want 00000100", o_epc); else n_pass++;
    n_total++; if (o_cause !== 4'h1) $display("FAIL irq_cause: got %h want 1", o_cause); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b0010) $display("FAIL irq_ack: got %b want 0010", o_irq_ack); else n_pass++;
    n_total++; if (o_in_handler !== 1'b1) $display("FAIL irq_in_handler: got %b want 1", o_in_handler); else n_pass++;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL irq_handler_hold: got %b want 0", o_interrupt); else n_pass++;
    i_irq = 4'b0;
    tick();
    n_total++; if (o_irq_ack !== 4'b0) $display("FAIL irq_ack_one_cycle: got %b want 0000", o_irq_ack); else n_pass++;
    do_return(4'b0);
  endtask

  task automatic test_exc_priority();
    i_irq = 4'b0001; i_exc_undef = 1'b1; i_id_pc = 32'h200;
    #1;
    n_total++; if (o_exception !== 1'b1) $display("FAIL exc_take: got %b want 1", o_exception); else n_pass++;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL exc_beats_irq: got %b want 0", o_interrupt); else n_pass++;
    tick();
    i_exc_undef = 1'b0;
    n_total++; if (o_epc !== 32'h204) $display("FAIL exc_epc: got %h want 00000204", o_epc); else n_pass++;
    n_total++; if (o_cause !== 4'hF) $display("FAIL exc_cause: got %h want f", o_cause); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b0) $display("FAIL exc_no_ack: got %b want 0000", o_irq_ack); else n_pass++;
    do_return(4'b0001);
    i_id_pc = 32'h300;
    #1;
    n_total++; if (o_interrupt !== 1'b1) $display("FAIL exc_irq_retaken: got %b want 1", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_cause !== 4'h0) $display("FAIL exc_irq_cause: got %h want 0", o_cause); else n_pass++;
    n_total++; if (o_epc !== 32'h300) $display("FAIL exc_irq_epc: got %h want 00000300", o_epc); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b0001) $display("FAIL exc_irq_ack: got %b want 0001", o_irq_ack); else n_pass++;
    i_irq = 4'b0;
    do_return(4'b0);
  endtask

  task automatic test_stall_redirect();
    i_irq = 4'b0001; i_id_pc = 32'h400; i_stall = 1'b1;
    #1;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL stall_blocks: got %b want 0", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL stall_idle: got %b want 0", o_in_handler); else n_pass++;
    i_stall = 1'b0; i_redirect = 1'b1;
    #1;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL redirect_blocks: got %b want 0", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL redirect_idle: got %b want 0", o_in_handler); else n_pass++;
    i_redirect = 1'b0; i_id_valid = 1'b0;
    #1;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL bubble_blocks: got %b want 0", o_interrupt); else n_pass++;
    i_id_valid = 1'b1;
    #1;
    n_total++; if (o_interrupt !== 1'b1) $display("FAIL clear_take: got %b want 1", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_epc !== 32'h400) $display("FAIL clear_epc: got %h want 00000400", o_epc); else n_pass++;
    i_irq = 4'b0;
    do_return(4'b0);
  endtask

  task automatic test_kernel_mode();
    i_id_pc = 32'h8000_0010; i_irq = 4'b0001; i_exc_undef = 1'b1;
    #1;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL kernel_no_int: got %b want 0", o_interrupt); else n_pass++;
    n_total++; if (o_exception !== 1'b0) $display("FAIL kernel_no_exc: got %b want 0", o_exception); else n_pass++;
    tick();
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL kernel_idle: got %b want 0", o_in_handler); else n_pass++;
    n_total++; if (o_epc !== 32'h400) $display("FAIL kernel_epc_hold: got %h want 00000400", o_epc); else n_pass++;
    i_exc_undef = 1'b0; i_irq = 4'b0;
  endtask

  task automatic test_reset_mid();
    i_id_pc = 32'h7FFF_FFFC; i_exc_undef = 1'b1;
    tick();
    i_exc_undef = 1'b0;
    n_total++; if (o_epc !== 32'h8000_0000) $display("FAIL exc_epc_top: got %h want 80000000", o_epc); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL midreset_idle: got %b want 0", o_in_handler); else n_pass++;
    n_total++; if (o_epc !== 32'h0) $display("FAIL midreset_epc: got %h want 0", o_epc); else n_pass++;
    n_total++; if (o_cause !== 4'h0) $display("FAIL midreset_cause: got %h want 0", o_cause); else n_pass++;
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL eret_idle_ignored: got %b want 0", o_in_handler); else n_pass++;
  endtask

  task automatic test_priority();
    i_irq = 4'b1100; i_id_pc = 32'h500;
    tick();
    n_total++; if (o_cause !== 4'h2) $display("FAIL prio_cause2: got %h want 2", o_cause); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b0100) $display("FAIL prio_ack2: got %b want 0100", o_irq_ack); else n_pass++;
    i_irq = 4'b0;
    do_return(4'b0);
    i_irq = 4'b1000;
    tick();
    n_total++; if (o_cause !== 4'h3) $display("FAIL prio_cause3: got %h want 3", o_cause); else n_pass++;
    n_total++; if (o_irq_ack !== 4'b1000) $display("FAIL prio_ack3: got %b want 1000", o_irq_ack); else n_pass++;
    i_irq = 4'b0;
    do_return(4'b0);
  endtask

  task automatic test_irq_pulse_in_handler();
    i_irq = 4'b0010; i_id_pc = 32'h600;
    tick();
    i_irq = 4'b0100;
    tick();
    i_irq = 4'b0;
    tick();
    do_return(4'b0);
    #1;
`ifdef IRQ_LATCH_EN
    n_total++; if (o_interrupt !== 1'b1) $display("FAIL latch_take: got %b want 1", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_cause !== 4'h2) $display("FAIL latch_cause: got %h want 2", o_cause); else n_pass++;
    do_return(4'b0);
    #1;
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL latch_cleared: got %b want 0", o_interrupt); else n_pass++;
`else
    n_total++; if (o_interrupt !== 1'b0) $display("FAIL level_lost: got %b want 0", o_interrupt); else n_pass++;
    tick();
    n_total++; if (o_in_handler !== 1'b0) $display("FAIL level_lost_idle: got %b want 0", o_in_handler); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_exc_priority();
    test_stall_redirect();
    test_kernel_mode();
    test_reset_mid();
    test_priority();
    test_irq_pulse_in_handler();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
